// File: rtl/mips_pkg.sv
// Shared MDU definitions: op codes, default widths, FSM state and step-mode encodings.
package mips_pkg;

  localparam int MDU_DATA_WIDTH = 32;
  localparam int MDU_CNT_WIDTH  = 6;

  localparam logic [2:0] MDU_OP_NOP   = 3'b000;
  localparam logic [2:0] MDU_OP_MULT  = 3'b001;
  localparam logic [2:0] MDU_OP_MULTU = 3'b010;
  localparam logic [2:0] MDU_OP_DIV   = 3'b011;
  localparam logic [2:0] MDU_OP_DIVU  = 3'b100;
  localparam logic [2:0] MDU_OP_MTHI  = 3'b101;
  localparam logic [2:0] MDU_OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage <-> MDU signal bundle; EX is the master, the MDU is the slave.
interface mult_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            mdu_op;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  hilo_rd;
    logic                  flush;
    logic                  busy;
    logic                  stall_req;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;

    modport master (
        output start, mdu_op, src_a, src_b, hilo_rd, flush,
        input  busy, stall_req, done, hi_out, lo_out
    );

    modport slave (
        input  start, mdu_op, src_a, src_b, hilo_rd, flush,
        output busy, stall_req, done, hi_out, lo_out
    );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on magnitudes.
// {part, lo} is the working register pair; the quotient bit enters lo at its LSB.
module mdu_step
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
    input  step_mode_e            mode,
    input  logic [DATA_WIDTH:0]   part,
    input  logic [DATA_WIDTH-1:0] lo,
    input  logic [DATA_WIDTH-1:0] operand,
    output logic [DATA_WIDTH:0]   next_part,
    output logic [DATA_WIDTH-1:0] next_lo,
    output logic                  q_bit
);

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH+1:0] diff;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_part = part;
        next_lo   = lo;
        q_bit     = 1'b0;
        sum       = part + {1'b0, operand};
        shifted   = {part[DATA_WIDTH-1:0], lo[DATA_WIDTH-1]};
        diff      = {1'b0, shifted} - {2'b00, operand};

        if (mode == STEP_MUL) begin
            if (lo[0]) begin
                next_part = {1'b0, sum[DATA_WIDTH:1]};
                next_lo   = {sum[0], lo[DATA_WIDTH-1:1]};
            end else begin
                next_part = {1'b0, part[DATA_WIDTH:1]};
                next_lo   = {part[0], lo[DATA_WIDTH-1:1]};
            end
        end else begin
            // Non-negative trial difference means the divisor fits: keep it, quotient bit 1.
            q_bit     = ~diff[DATA_WIDTH+1];
            next_part = q_bit ? diff[DATA_WIDTH:0] : shifted;
            next_lo   = {lo[DATA_WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: owns HI/LO, runs one radix-2 step per cycle,
// and requests a pipeline stall when EX needs the unit or HI/LO while busy.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DATA_WIDTH,
    parameter int CNT_WIDTH  = MDU_CNT_WIDTH
) (
    input logic            clk,
    input logic            rst_n,
    mult_div_unit_if.slave bus
);

    localparam int W = DATA_WIDTH;

    mdu_state_e           state, state_next;
    logic [CNT_WIDTH-1:0] cnt;
    step_mode_e           mode;
    logic                 neg_res, neg_rem, div_zero;
    logic [W-1:0]         operand, lo_acc, hi_q, lo_q;
    logic [W:0]           part;

    logic [W:0]           step_part;
    logic [W-1:0]         step_lo;
    logic                 step_qbit;

    logic                 iter_op, signed_op, accept, a_neg, b_neg;
    logic [W-1:0]         mag_a, mag_b;
    logic [2*W-1:0]       prod;
    logic [W-1:0]         quo, rem, res_hi, res_lo;

    mdu_step #(.DATA_WIDTH(W)) u_step (
        .mode      (mode),
        .part      (part),
        .lo        (lo_acc),
        .operand   (operand),
        .next_part (step_part),
        .next_lo   (step_lo),
        .q_bit     (step_qbit)
    );

    always_comb begin
        iter_op   = bus.mdu_op inside {MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU};
        signed_op = (bus.mdu_op == MDU_OP_MULT) || (bus.mdu_op == MDU_OP_DIV);
        accept    = (state == MDU_IDLE) && bus.start && !bus.flush && iter_op;
        a_neg     = signed_op && bus.src_a[W-1];
        b_neg     = signed_op && bus.src_b[W-1];
        mag_a     = a_neg ? -bus.src_a : bus.src_a;
        mag_b     = b_neg ? -bus.src_b : bus.src_b;
    end

    always_comb begin
        state_next = state;
        case (state)
            MDU_IDLE: if (accept) state_next = MDU_RUN;
            MDU_RUN:  if (cnt == CNT_WIDTH'(W - 1)) state_next = MDU_FIX;
            MDU_FIX:  state_next = MDU_IDLE;
            default:  state_next = MDU_IDLE;
        endcase
        if (bus.flush) state_next = MDU_IDLE;
    end

    // Sign correction of the magnitude result; divide-by-zero forces an all-ones quotient.
    always_comb begin
        prod = {part[W-1:0], lo_acc};
        if (neg_res) prod = -prod;
        quo = lo_acc;
        rem = part[W-1:0];
        if (mode == STEP_MUL) begin
            res_hi = prod[2*W-1:W];
            res_lo = prod[W-1:0];
        end else begin
            res_hi = neg_rem ? -rem : rem;
            res_lo = div_zero ? '1 : (neg_res ? -quo : quo);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state <= MDU_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept)                 cnt <= '0;
            else if (state == MDU_RUN)  cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode     <= STEP_MUL;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            operand  <= '0;
            part     <= '0;
            lo_acc   <= '0;
        end else if (accept) begin
            mode     <= (bus.mdu_op == MDU_OP_DIV || bus.mdu_op == MDU_OP_DIVU) ? STEP_DIV : STEP_MUL;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (bus.src_b == '0);
            part     <= '0;
            // Multiply shifts the multiplier out of lo_acc; divide shifts the dividend out.
            if (bus.mdu_op == MDU_OP_DIV || bus.mdu_op == MDU_OP_DIVU) begin
                operand <= mag_b;
                lo_acc  <= mag_a;
            end else begin
                operand <= mag_a;
                lo_acc  <= mag_b;
            end
        end else if (state == MDU_RUN) begin
            part   <= step_part;
            lo_acc <= step_lo | {{(W-1){1'b0}}, step_qbit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (!bus.flush) begin
            if (state == MDU_FIX) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state == MDU_IDLE && bus.start) begin
                if (bus.mdu_op == MDU_OP_MTHI) hi_q <= bus.src_a;
                if (bus.mdu_op == MDU_OP_MTLO) lo_q <= bus.src_a;
            end
        end
    end

    assign bus.busy      = (state != MDU_IDLE);
    assign bus.stall_req = bus.busy && (bus.start || bus.hilo_rd);
    assign bus.done      = (state == MDU_FIX) && !bus.flush;
    assign bus.hi_out    = hi_q;
    assign bus.lo_out    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: reference model feeds a scoreboard queue,
// results are popped and compared the cycle after done.
module tb_mult_div_unit;
    import mips_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    mult_div_unit_if #(.DATA_WIDTH(32)) bus ();

    mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sbv;
        logic [63:0] p, q, r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        p   = '0;
        q   = '0;
        r   = '0;
        e   = '0;
        case (op)
            MDU_OP_MULT:  begin p = sa * sbv; e = {p[63:32], p[31:0]}; end
            MDU_OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; e = {p[63:32], p[31:0]}; end
            MDU_OP_DIV: begin
                if (b == 32'd0) e = {a, 32'hFFFF_FFFF};
                else begin q = sa / sbv; r = sa % sbv; e = {r[31:0], q[31:0]}; end
            end
            MDU_OP_DIVU: begin
                if (b == 32'd0) e = {a, 32'hFFFF_FFFF};
                else e = {a % b, a / b};
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start cycle (cycle T); returns positioned in cycle T+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back(model(op, a, b));
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.src_a  = a;
        bus.src_b  = b;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] data);
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.src_a  = data;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_hi"}, {32'd0, bus.hi_out}, {32'd0, e.hi});
            check({tag, "_lo"}, {32'd0, bus.lo_out}, {32'd0, e.lo});
        end
    endtask

    // Called in cycle T+1; expects done in T+33 and the result visible in T+34.
    task automatic wait_result(input string tag);
        int n;
        n = 1;
        check({tag, "_busy_t1"}, {63'd0, bus.busy}, 64'd1);
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_done_cycle"}, 64'(n), 64'd33);
        tick();
        check({tag, "_busy_after"}, {63'd0, bus.busy}, 64'd0);
        compare_result(tag);
    endtask

    initial begin
        int          n, bad, pulses;
        logic [2:0]  ops[4];
        logic [31:0] ra, rb;
        checks      = 0;
        failures    = 0;
        ops         = '{MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU};
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.mdu_op  = MDU_OP_NOP;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.hilo_rd = 1'b0;
        bus.flush   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_hi", {32'd0, bus.hi_out}, 64'd0);
        check("rst_lo", {32'd0, bus.lo_out}, 64'd0);

        issue(MDU_OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);  wait_result("mult_neg");
        issue(MDU_OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003); wait_result("multu");
        issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);   wait_result("div_neg");
        issue(MDU_OP_DIVU, 32'd7, 32'd2);                  wait_result("divu");
        issue(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);   wait_result("div_ovf");
        issue(MDU_OP_DIVU, 32'h0000_1234, 32'd0);          wait_result("divu_zero");
        issue(MDU_OP_DIV, 32'hFFFF_FFF8, 32'd0);           wait_result("div_zero_neg");
        issue(MDU_OP_MULT, 32'h8000_0000, 32'h8000_0000);  wait_result("mult_min");

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom;
            if (i == 2) rb = rb >> 20;
            issue(ops[i % 4], ra, rb);
            wait_result($sformatf("rand%0d", i));
        end

        // Read of HI/LO right behind a MULT stalls until the result lands.
        issue(MDU_OP_MULT, 32'd5, 32'd6);
        bus.hilo_rd = 1'b1;
        n   = 1;
        bad = 0;
        while (!bus.done && n < 40) begin
            if (!bus.stall_req) bad++;
            tick();
            n++;
        end
        if (!bus.stall_req) bad++;
        check("haz_done_cycle", 64'(n), 64'd33);
        check("haz_stall_missing", 64'(bad), 64'd0);
        tick();
        check("haz_stall_release", {63'd0, bus.stall_req}, 64'd0);
        compare_result("haz_mult");
        bus.hilo_rd = 1'b0;

        // A second start held through the busy window is accepted at T+34.
        issue(MDU_OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        exp_q.push_back(model(MDU_OP_DIVU, 32'd100, 32'd9));
        bus.start  = 1'b1;
        bus.mdu_op = MDU_OP_DIVU;
        bus.src_a  = 32'd100;
        bus.src_b  = 32'd9;
        n   = 1;
        bad = 0;
        while (!bus.done && n < 40) begin
            if (!bus.stall_req) bad++;
            tick();
            n++;
        end
        if (!bus.stall_req) bad++;
        check("hold_done_cycle", 64'(n), 64'd33);
        check("hold_stall_missing", 64'(bad), 64'd0);
        tick();
        check("hold_stall_release", {63'd0, bus.stall_req}, 64'd0);
        compare_result("hold_first");
        tick();
        bus.start = 1'b0;
        wait_result("hold_second");

        // Flush mid-run leaves the preloaded HI/LO alone.
        move_to(MDU_OP_MTHI, 32'hA5A5_A5A5);
        move_to(MDU_OP_MTLO, 32'hA5A5_A5A5);
        check("mthi_hi", {32'd0, bus.hi_out}, 64'hA5A5_A5A5);
        check("mtlo_lo", {32'd0, bus.lo_out}, 64'hA5A5_A5A5);
        issue(MDU_OP_DIVU, 32'd1000, 32'd7);
        repeat (14) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", {63'd0, bus.busy}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.done) pulses++;
            tick();
        end
        check("flush_done_pulses", 64'(pulses), 64'd0);
        check("flush_hi", {32'd0, bus.hi_out}, 64'hA5A5_A5A5);
        check("flush_lo", {32'd0, bus.lo_out}, 64'hA5A5_A5A5);
        void'(exp_q.pop_front());

        // Flush landing on the fix-up cycle suppresses both done and the write.
        issue(MDU_OP_MULTU, 32'd1234, 32'd5678);
        n = 1;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        check("fixflush_cycle", 64'(n), 64'd33);
        bus.flush = 1'b1;
        #1;
        check("fixflush_done", {63'd0, bus.done}, 64'd0);
        tick();
        bus.flush = 1'b0;
        check("fixflush_busy", {63'd0, bus.busy}, 64'd0);
        check("fixflush_hi", {32'd0, bus.hi_out}, 64'hA5A5_A5A5);
        check("fixflush_lo", {32'd0, bus.lo_out}, 64'hA5A5_A5A5);
        void'(exp_q.pop_front());

        // Start coincident with flush, NOP and undefined ops have no effect.
        bus.flush = 1'b1;
        move_to(MDU_OP_DIVU, 32'd9);
        bus.flush = 1'b0;
        check("flush_start_busy", {63'd0, bus.busy}, 64'd0);
        move_to(MDU_OP_NOP, 32'h1111_1111);
        check("nop_busy", {63'd0, bus.busy}, 64'd0);
        move_to(3'b111, 32'h2222_2222);
        check("undef_busy", {63'd0, bus.busy}, 64'd0);
        check("undef_hi", {32'd0, bus.hi_out}, 64'hA5A5_A5A5);
        check("undef_lo", {32'd0, bus.lo_out}, 64'hA5A5_A5A5);

        // MTLO followed by MFLO: no stall, new value visible.
        move_to(MDU_OP_MTLO, 32'h1357_9BDF);
        bus.hilo_rd = 1'b1;
        #1;
        check("mflo_stall", {63'd0, bus.stall_req}, 64'd0);
        check("mflo_value", {32'd0, bus.lo_out}, 64'h1357_9BDF);
        bus.hilo_rd = 1'b0;

        // Asynchronous reset in the middle of a run.
        move_to(MDU_OP_MTHI, 32'hDEAD_BEEF);
        issue(MDU_OP_MULT, 32'd123, 32'd456);
        repeat (9) tick();
        bus.hilo_rd = 1'b1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_stall", {63'd0, bus.stall_req}, 64'd0);
        check("arst_done", {63'd0, bus.done}, 64'd0);
        check("arst_hi", {32'd0, bus.hi_out}, 64'd0);
        check("arst_lo", {32'd0, bus.lo_out}, 64'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        bus.hilo_rd = 1'b0;
        tick();
        check("arst_idle", {63'd0, bus.busy}, 64'd0);
        issue(MDU_OP_DIV, 32'd77, 32'hFFFF_FFF5);
        wait_result("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
